// File: rtl/shift_out_serializer_pkg.sv
// Shared state encoding and default parameters for the shift-out serializer.
package shift_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 8;

endpackage

// File: rtl/shift_out_serializer_phase_timer.sv
// Loadable down-counter timing one CLK_DIV-cycle phase; pulses phase_done on its last cycle.
module phase_timer #(
    parameter int unsigned CLK_DIV = shift_out_pkg::DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_done
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = CW'(CLK_DIV - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign phase_done = run_q && (cnt_q == '0);

endmodule

// File: rtl/shift_out_serializer.sv
// Framed parallel-to-serial driver for a 74HC595-style chain: sclk/sdata per bit, then a latch pulse.
module shift_out_serializer
    import shift_out_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             latch_q, latch_d;
    logic             timer_load;
    logic             phase_done;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        latch_d    = latch_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    sreg_d     = tx_data;
                    bit_cnt_d  = BCW'(WIDTH - 1);
                    sclk_d     = 1'b0;
                    sdata_d    = head_bit(tx_data);
                    latch_d    = 1'b0;
                    timer_load = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // sclk_q doubles as the phase flag: low phase ends by raising it, high phase by advancing a bit
                if (phase_done) begin
                    timer_load = 1'b1;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == '0) begin
                        sclk_d  = 1'b0;
                        sdata_d = 1'b0;
                        latch_d = 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        sreg_d    = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                        sdata_d   = head_bit(sreg_d);
                        sclk_d    = 1'b0;
                    end
                end
            end
            ST_LATCH: begin
                if (phase_done) begin
                    latch_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                latch_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = ~tx_ready;
    assign sclk     = sclk_q;
    assign sdata    = sdata_q;
    assign latch    = latch_q;

endmodule
